// File: rtl/fpga_uart_pkg.sv
// fpga_uart_pkg: shared types, limits and helpers for the FPGA UART blocks.
// fpga_uart_rx honours the build macro FPGA_UART_RX_MAJORITY_EN.
package fpga_uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_EVEN,
    PARITY_ODD
  } parity_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_rx_state_e;

  localparam int unsigned DATA_WIDTH_MIN = 5;
  localparam int unsigned DATA_WIDTH_MAX = 9;
  localparam int unsigned OVERSAMPLE_MIN = 4;

  function automatic int unsigned baud_div(
    input int unsigned clk_hz,
    input int unsigned baud,
    input int unsigned os
  );
    int unsigned d;
    d = clk_hz / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/fpga_uart_baud_tick.sv
// fpga_uart_baud_tick: oversample tick divider with synchronous restart.
// Shared by the UART receive path and the future parametrised transmitter.
module fpga_uart_baud_tick
  import fpga_uart_pkg::*;
#(
  parameter int unsigned DIV = 54
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = !restart_i && (cnt_q == C_LAST);

  // Free-running clock divider; restart realigns phase to a start edge.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_q <= '0;
    end else if (restart_i || cnt_q == C_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/fpga_uart_rx.sv
// fpga_uart_rx: parametrised UART receiver with one-entry holding register.
// Build macro FPGA_UART_RX_MAJORITY_EN enables 2-of-3 bit voting.
module fpga_uart_rx
  import fpga_uart_pkg::*;
#(
  parameter int unsigned  CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned  BAUD_RATE   = 115_200,
  parameter int unsigned  OVERSAMPLE  = 16,
  parameter int unsigned  DATA_WIDTH  = 8,
  parameter parity_mode_e PARITY_MODE = PARITY_NONE,
  parameter int unsigned  STOP_BITS   = 1
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  uart_rx_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  parity_err_o,
  output logic                  frame_err_o,
  output logic                  overrun_o,
  output logic                  busy_o
);

  localparam int unsigned DIV =
    baud_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_WIDTH);

  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

`ifdef FPGA_UART_RX_MAJORITY_EN
  localparam logic [TW-1:0] T_V0   = TW'(OVERSAMPLE / 2 - 2);
  localparam logic [TW-1:0] T_V1   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_SAMP = TW'(OVERSAMPLE / 2);
`else
  localparam logic [TW-1:0] T_SAMP = TW'(OVERSAMPLE / 2 - 1);
`endif

  if (DATA_WIDTH < DATA_WIDTH_MIN ||
      DATA_WIDTH > DATA_WIDTH_MAX ||
      OVERSAMPLE < OVERSAMPLE_MIN ||
      (OVERSAMPLE % 2) != 0 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_cfg_err
    $error("fpga_uart_rx: unsupported parameters");
  end

  uart_rx_state_e state_q, state_d;

  logic [1:0]            sync_q;
  logic                  rx_s;
  logic                  tick;
  logic                  start_det;
  logic                  samp_evt;
  logic                  bit_end;
  logic                  bit_val;
  logic                  done;
  logic                  frame_bad;
  logic                  par_bad;

  logic [TW-1:0]         tick_cnt_q;
  logic [BW-1:0]         bit_cnt_q;
  logic                  stop_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_q;
  logic                  ferr_q;

  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  perr_h_q;
  logic                  ferr_h_q;
  logic                  ovr_q;

  // Two-flop synchroniser; idles high so reset looks like a quiet line.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], uart_rx_i};
    end
  end

  assign rx_s      = sync_q[1];
  assign start_det = (state_q == ST_IDLE) && !rx_s;

  fpga_uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk_i     (clk_i),
    .arst_i    (arst_i),
    .restart_i (start_det),
    .tick_o    (tick)
  );

  assign samp_evt = tick && (tick_cnt_q == T_SAMP);
  assign bit_end  = tick && (tick_cnt_q == T_LAST);

`ifdef FPGA_UART_RX_MAJORITY_EN
  logic v0_q;
  logic v1_q;

  // Capture the two early votes around the bit centre.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      v0_q <= 1'b1;
      v1_q <= 1'b1;
    end else begin
      if (tick && tick_cnt_q == T_V0) v0_q <= rx_s;
      if (tick && tick_cnt_q == T_V1) v1_q <= rx_s;
    end
  end

  assign bit_val = (v0_q & v1_q) | (v0_q & rx_s) | (v1_q & rx_s);
`else
  assign bit_val = rx_s;
`endif

  assign done = (state_q == ST_STOP) && samp_evt &&
                (stop_cnt_q == STOP_LAST);
  assign frame_bad = ferr_q | ~bit_val;
  assign par_bad = (PARITY_MODE == PARITY_NONE) ? 1'b0 :
                   ((^shift_q ^ par_q) != (PARITY_MODE == PARITY_ODD));

  // FSM state register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode: bits advance on bit boundaries, stop ends early.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (samp_evt && bit_val) state_d = ST_IDLE;
        else if (bit_end)        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && bit_cnt_q == B_LAST) begin
          state_d = (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (done) state_d = frame_bad ? ST_WAIT_HIGH : ST_IDLE;
      end
      ST_WAIT_HIGH: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bit-phase counters and the receive shift register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else if (start_det) begin
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      if (tick) begin
        tick_cnt_q <= (tick_cnt_q == T_LAST) ? '0 : tick_cnt_q + 1'b1;
      end
      if (state_q == ST_DATA && bit_end) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      if (state_q == ST_DATA && samp_evt) begin
        shift_q <= {bit_val, shift_q[DATA_WIDTH-1:1]};
      end
      if (state_q == ST_PARITY && samp_evt) begin
        par_q <= bit_val;
      end
      if (state_q == ST_STOP && bit_end) begin
        stop_cnt_q <= 1'b1;
      end
      if (state_q == ST_STOP && samp_evt && !bit_val) begin
        ferr_q <= 1'b1;
      end
    end
  end

  // Holding register: load when free or drained this cycle, else drop.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      perr_h_q <= 1'b0;
      ferr_h_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (done && (!valid_q || ready_i)) begin
        data_q   <= shift_q;
        valid_q  <= 1'b1;
        perr_h_q <= par_bad;
        ferr_h_q <= frame_bad;
      end else begin
        if (done)    ovr_q   <= 1'b1;
        if (ready_i) valid_q <= 1'b0;
      end
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = perr_h_q;
  assign frame_err_o  = ferr_h_q;
  assign overrun_o    = ovr_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule
